// File: rtl/vga_timing_ctrl.sv
// Raster sequencer for 640x480@60: halves clock_50 into a pixel tick, runs the
// h/v counters and delays sync/blank by PIPE_DLY clocks to line up with registered RGB.
module vga_timing_ctrl #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       en,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    // {hsync, vsync, blank_n} while idle or in reset
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [9:0] x_d, y_d;
    logic       running;
    logic [2:0] sync_pre;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            pix_x   <= '0;
            pix_y   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pix_x   <= x_d;
            pix_y   <= y_d;
        end
    end

    // Dropping en takes priority over a pending pixel tick.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        x_d     = pix_x;
        y_d     = pix_y;
        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                x_d     = '0;
                y_d     = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    phase_d = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (pix_x == H_LAST) begin
                            x_d = '0;
                            y_d = (pix_y == V_LAST) ? '0 : pix_y + 10'd1;
                        end else begin
                            x_d = pix_x + 10'd1;
                        end
                    end
                end
            end
        endcase
    end

    assign running    = (state_q == RUN);
    assign pixel_tick = running & phase_q;
    assign frame_tick = pixel_tick && (pix_x == H_LAST) && (pix_y == V_LAST);
    assign video_on   = running && (pix_x < H_VIS_W) && (pix_y < V_VIS_W);

    assign sync_pre = {~(running && (pix_x >= HS_BEG) && (pix_x <= HS_END)),
                       ~(running && (pix_y >= VS_BEG) && (pix_y <= VS_END)),
                       video_on};

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {hsync, vsync, blank_n} = sync_pre;
        end else begin : g_dly
            logic [PIPE_DLY-1:0][2:0] dly_q;

            // Runs every clock_50, independent of the pixel tick.
            always_ff @(posedge clock_50 or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= SYNC_IDLE;
                end else begin
                    dly_q[0] <= sync_pre;
                    for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign {hsync, vsync, blank_n} = dly_q[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: full-size raster against a reference
// model, plus a shrunken raster instance for whole-frame behaviour.
module tb_vga_timing_ctrl;
    localparam int D   = 1;
    localparam int HT  = 800;
    localparam int VT  = 525;
    localparam int SD  = 2;
    localparam int SHT = 16;
    localparam int SVT = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic vo, pt, ft, hs, vs, bn;
    } obs_t;

    localparam obs_t IDLE_OBS = {10'd0, 10'd0, 6'b000110};

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       en       = 1'b0;
    logic [9:0] pix_x, pix_y;
    logic       video_on, pixel_tick, frame_tick, hsync, vsync, blank_n;
    logic [9:0] s_x, s_y;
    logic       s_vo, s_pt, s_ft, s_hs, s_vs, s_bn;

    int   vectors = 0;
    int   errors  = 0;
    obs_t exp_q[$];
    logic [2:0] hist[$];
    bit   m_run;
    int   m_k;

    vga_timing_ctrl #(.PIPE_DLY(D)) dut (
        .clock_50(clock_50), .reset_n(reset_n), .en(en),
        .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .pixel_tick(pixel_tick), .frame_tick(frame_tick),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n)
    );

    vga_timing_ctrl #(
        .H_VIS(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(SD)
    ) dut_small (
        .clock_50(clock_50), .reset_n(reset_n), .en(en),
        .pix_x(s_x), .pix_y(s_y), .video_on(s_vo),
        .pixel_tick(s_pt), .frame_tick(s_ft),
        .hsync(s_hs), .vsync(s_vs), .blank_n(s_bn)
    );

    always #10 clock_50 = ~clock_50;

    task automatic model_reset();
        m_run = 1'b0;
        m_k   = 0;
        hist.delete();
        exp_q.delete();
        for (int i = 0; i <= D; i++) hist.push_back(3'b110);
    endtask

    // Predict the state after the coming edge, push it, then pop and compare.
    task automatic step(input string name);
        obs_t e, got;
        int p;
        logic [2:0] pre;
        if (!en) begin
            m_run = 1'b0; m_k = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_k = 0;
        end else begin
            m_k++;
        end
        p    = m_k / 2;
        e.x  = m_run ? 10'(p % HT) : 10'd0;
        e.y  = m_run ? 10'((p / HT) % VT) : 10'd0;
        e.pt = m_run && (m_k % 2 == 1);
        e.vo = m_run && (e.x < 640) && (e.y < 480);
        e.ft = e.pt && (e.x == 799) && (e.y == 524);
        pre  = {!(m_run && e.x >= 656 && e.x <= 751),
                !(m_run && e.y >= 490 && e.y <= 491), e.vo};
        hist.push_back(pre);
        if (hist.size() > D + 1) void'(hist.pop_front());
        {e.hs, e.vs, e.bn} = hist[0];
        exp_q.push_back(e);
        @(posedge clock_50); #1;
        got = {pix_x, pix_y, video_on, pixel_tick, frame_tick, hsync, vsync, blank_n};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s k=%0d: got x=%0d y=%0d vo/pt/ft/hs/vs/bn=%b, expected x=%0d y=%0d vo/pt/ft/hs/vs/bn=%b",
                     name, m_k, got.x, got.y, got[5:0], e.x, e.y, e[5:0]);
        end
    endtask

    task automatic test_reset();
        obs_t got;
        reset_n = 1'b0;
        en      = 1'b0;
        #25;
        got = {pix_x, pix_y, video_on, pixel_tick, frame_tick, hsync, vsync, blank_n};
        vectors++;
        if (got !== IDLE_OBS) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, IDLE_OBS);
        end
        @(posedge clock_50); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_start();
        en = 1'b1;
        step("start_k0");
        step("start_k1");
        vectors++;
        if (pixel_tick !== 1'b1 || pix_x !== 10'd0) begin
            errors++;
            $display("FAIL first_tick: got tick=%b x=%0d expected tick=1 x=0", pixel_tick, pix_x);
        end
        step("start_k2");
        vectors++;
        if (pix_x !== 10'd1) begin
            errors++;
            $display("FAIL first_advance: got x=%0d expected 1", pix_x);
        end
    endtask

    task automatic test_line_wrap();
        int low = 0;
        int k656 = -1;
        int khs = -1;
        repeat (1600) begin
            step("line");
            if (pix_x == 10'd656 && k656 < 0) k656 = m_k;
            if (hsync === 1'b0) begin
                low++;
                if (khs < 0) khs = m_k;
            end
        end
        vectors++;
        if (low != 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d clocks expected 192", low);
        end
        vectors++;
        if (k656 < 0 || khs - k656 != D) begin
            errors++;
            $display("FAIL hsync_delay: got %0d clocks expected %0d", khs - k656, D);
        end
        vectors++;
        if (pix_y !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap_y: got %0d expected 1", pix_y);
        end
    endtask

    task automatic test_visible();
        int vo_fall = -1, bn_fall = -1, vo_rise = -1, bn_rise = -1;
        logic pvo = video_on;
        logic pbn = blank_n;
        repeat (1600) begin
            step("visible");
            if (pvo && !video_on && vo_fall < 0) begin
                vo_fall = m_k;
                vectors++;
                if (pix_x !== 10'd640) begin
                    errors++;
                    $display("FAIL video_off_col: got x=%0d expected 640", pix_x);
                end
            end
            if (!pvo && video_on && vo_rise < 0) vo_rise = m_k;
            if (pbn && !blank_n && bn_fall < 0) bn_fall = m_k;
            if (!pbn && blank_n && bn_rise < 0) bn_rise = m_k;
            pvo = video_on;
            pbn = blank_n;
        end
        vectors++;
        if (vo_fall < 0 || bn_fall - vo_fall != D) begin
            errors++;
            $display("FAIL blank_fall_delay: got %0d expected %0d", bn_fall - vo_fall, D);
        end
        vectors++;
        if (vo_rise < 0 || bn_rise - vo_rise != D) begin
            errors++;
            $display("FAIL blank_rise_delay: got %0d expected %0d", bn_rise - vo_rise, D);
        end
    endtask

    task automatic test_drop_en();
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step("seek400");
            if (pix_x == 10'd400 && pixel_tick === 1'b1) found = 1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL seek_400: got no tick at x=400 expected one within 2000 clocks");
        end
        en = 1'b0;
        step("drop_en");
        vectors++;
        if (pix_x !== 10'd0 || pix_y !== 10'd0 || video_on !== 1'b0 || pixel_tick !== 1'b0) begin
            errors++;
            $display("FAIL drop_en: got x=%0d y=%0d vo=%b pt=%b expected 0 0 0 0",
                     pix_x, pix_y, video_on, pixel_tick);
        end
        repeat (3) step("idle");
        en = 1'b1;
        repeat (3) step("restart");
        vectors++;
        if (pix_x !== 10'd1 || pix_y !== 10'd0) begin
            errors++;
            $display("FAIL restart: got x=%0d y=%0d expected 1 0", pix_x, pix_y);
        end
    endtask

    task automatic test_frame();
        int ticks = 0, first = -1, second = -1, vlow = 0;
        bit after = 0;
        en = 1'b0;
        step("frame_idle");
        en = 1'b1;
        repeat (600) begin
            step("frame");
            if (after) begin
                after = 0;
                vectors++;
                if (s_x !== 10'd0 || s_y !== 10'd0) begin
                    errors++;
                    $display("FAIL frame_origin: got x=%0d y=%0d expected 0 0", s_x, s_y);
                end
            end
            if (s_ft === 1'b1) begin
                ticks++;
                after = 1;
                if (first < 0) first = m_k;
                else if (second < 0) second = m_k;
            end
            if (first >= 0 && second < 0 && s_vs === 1'b0) vlow++;
        end
        vectors++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL frame_tick_count: got %0d expected 2", ticks);
        end
        vectors++;
        if (second - first != 2 * SHT * SVT) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", second - first, 2 * SHT * SVT);
        end
        vectors++;
        if (vlow != 2 * 2 * SHT) begin
            errors++;
            $display("FAIL vsync_width: got %0d expected %0d", vlow, 2 * 2 * SHT);
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        #4;
        reset_n = 1'b0;
        #1;
        got = {pix_x, pix_y, video_on, pixel_tick, frame_tick, hsync, vsync, blank_n};
        vectors++;
        if (got !== IDLE_OBS) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, IDLE_OBS);
        end
        @(posedge clock_50); #1;
        reset_n = 1'b1;
        model_reset();
        repeat (4) step("post_reset");
    endtask

    initial begin
        test_reset();
        test_start();
        test_line_wrap();
        test_visible();
        test_drop_en();
        test_frame();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
